// File: rtl/arb16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: sizes, FSM state
// encoding and the wrap-around priority search used to pick a winner.
package arb16_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  // First set bit of req, scanning upward from ptr and wrapping 15 -> 0.
  // With req == 0 it returns ptr; callers only use it when req != 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb16_rr_ctrl_dec.sv
// 4-bit index to 16-bit one-hot decoder; output forced to zero when en is low.
module dec4to16_onehot
  import arb16_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  // Shift a single set bit into position, gated by the enable.
  assign onehot = en ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/arb16_rr_ctrl.sv
// Round-robin arbiter and grant sequencer for the 16-way one-hot select
// decoder. IDLE arbitrates, GRANT holds one owner, COOL inserts one dead
// cycle before the next arbitration.
// Optional hold timeout is built only when ARB_TIMEOUT_EN is defined.
module arb16_rr_ctrl
  import arb16_pkg::*;
#(
  parameter int MAX_HOLD = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("arb16_rr_ctrl: MAX_HOLD must be in 1..65535");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             hold_hit;
  logic             release_now;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;

  assign hold_hit = (state == GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Hold counter: zeroed while idle (so it is clear on entry to GRANT),
  // counts each GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // Any release source ends the grant; simultaneous sources are one release.
  assign release_now = done | ~req[gnt_idx] | hold_hit;

  // Main sequencer: state, winner index, rotation pointer and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx <= rr_pick(req, ptr);
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr     <= gnt_idx + IDX_W'(1);
            state   <= COOL;
            // A voluntary done on the same edge takes precedence.
            timeout <= hold_hit & ~done;
          end
        end
        COOL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign gnt_valid = (state == GRANT);
  assign busy      = (state != IDLE);

  dec4to16_onehot u_dec (
    .idx    (gnt_idx),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_arb16_rr_ctrl.sv
// Scoreboard bench for arb16_rr_ctrl: the stimulus process queues the grants
// it expects, a negedge monitor pops and compares each grant as it appears.
module tb_arb16_rr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        busy;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  idx;
    int          gap;   // expected zero cycles before this grant, -1 = skip
    int          len;   // expected grant length, 0 = skip
    logic        tmo;   // expected timeout in the cycle after the grant ends
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  arb16_rr_ctrl #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] g, input logic [3:0] idx, input int gap,
                      input int len, input logic tmo);
    exp_t e;
    e.g = g; e.idx = idx; e.gap = gap; e.len = len; e.tmo = tmo;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (gnt_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (gnt_valid !== 1'b1) check("wait_grant_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_release();
    int n = 0;
    while (gnt_valid !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    if (gnt_valid !== 1'b0) check("wait_release_expired", 32'd0, 32'd1);
  endtask

  // Monitor: pops one expected entry per grant rising edge, tracks gap and length.
  exp_t cur;
  logic prev_v  = 1'b0;
  int   zeros   = 0;
  int   len_cnt = 0;

  always @(negedge clk) begin
    if (gnt_valid === 1'b1 && prev_v !== 1'b1) begin
      if (q.size() == 0) begin
        check("sb_unexpected_grant", {16'h0, gnt}, 32'h0);
      end else begin
        cur = q.pop_front();
        check("sb_gnt", {16'h0, gnt}, {16'h0, cur.g});
        check("sb_idx", {28'h0, gnt_idx}, {28'h0, cur.idx});
        if (cur.gap >= 0) check("sb_gap", zeros, cur.gap);
      end
      len_cnt = 1;
    end else if (gnt_valid === 1'b1) begin
      len_cnt++;
      check("sb_gnt_hold", {16'h0, gnt}, {16'h0, cur.g});
    end else begin
      if (prev_v === 1'b1) begin
        if (cur.len > 0) check("sb_len", len_cnt, cur.len);
        check("sb_timeout", {31'h0, timeout}, {31'h0, cur.tmo});
        zeros = 0;
      end
      zeros++;
      check("sb_idle_gnt", {16'h0, gnt}, 32'h0);
    end
    prev_v = gnt_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] one;
    logic [3:0]  wrap_seq [4];
    one = 16'h0001;
    wrap_seq[0] = 4'd0; wrap_seq[1] = 4'd15; wrap_seq[2] = 4'd0; wrap_seq[3] = 4'd15;

    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state held while no requests
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_gnt", {16'h0, gnt}, 32'h0);
      check("rst_idx", {28'h0, gnt_idx}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_timeout", {31'h0, timeout}, 32'h0);
    end

    // Single requester: grant latency, done release, 2-cycle gap, req-drop release
    push(16'h0001, 4'd0, -1, 3, 1'b0);
    push(16'h0001, 4'd0, 2, 2, 1'b0);
    req = 16'h0001;
    step();
    check("t2_grant_latency", {16'h0, gnt}, 32'h0001);
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("t2_cool_gnt", {16'h0, gnt}, 32'h0);
    check("t2_cool_busy", {31'h0, busy}, 32'h1);
    step();
    check("t2_idle_gnt", {16'h0, gnt}, 32'h0);
    step();
    check("t2_regrant", {16'h0, gnt}, 32'h0001);
    step();
    req = 16'h0000;
    step();
    step();
    step();

    // All requesters: rotation 0..15 then back to 0
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push(one << (i % 16), 4'(i % 16), (i == 0) ? -1 : 2, 1, 1'b0);
    end
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      wait_grant();
      done = 1'b1;
      step();
      done = 1'b0;
    end
    req = 16'h0000;
    step();
    step();

    // Two requesters at opposite ends: pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(one << wrap_seq[i], wrap_seq[i], (i == 0) ? -1 : 2, 1, 1'b0);
    end
    req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      done = 1'b1;
      step();
      done = 1'b0;
    end
    req = 16'h0000;
    step();
    step();

    // Hold with no done; non-holder request changes mid-grant are ignored
    do_reset();
`ifdef ARB_TIMEOUT_EN
    push(16'h0010, 4'd4, -1, 8, 1'b1);
    push(16'h0010, 4'd4, 2, 0, 1'b0);
    req = 16'h0010;
    wait_grant();
    req = 16'h0013;
    step();
    step();
    req = 16'h0010;
    wait_release();
    check("tmo_pulse", {31'h0, timeout}, 32'h1);
    step();
    check("tmo_pulse_width", {31'h0, timeout}, 32'h0);
    wait_grant();
    step();
    step();
`else
    push(16'h0010, 4'd4, -1, 0, 1'b0);
    req = 16'h0010;
    wait_grant();
    req = 16'h0013;
    step();
    step();
    req = 16'h0010;
    for (int i = 0; i < 30; i++) begin
      step();
      check("hold_gnt", {16'h0, gnt}, 32'h0010);
      check("hold_timeout", {31'h0, timeout}, 32'h0);
    end
`endif

    // Reset in the middle of a grant, then pointer restarts at 0
    push(16'h0002, 4'd1, -1, 0, 1'b0);
    rst = 1'b1;
    step();
    check("midrst_gnt", {16'h0, gnt}, 32'h0);
    check("midrst_idx", {28'h0, gnt_idx}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_timeout", {31'h0, timeout}, 32'h0);
    rst = 1'b0;
    req = 16'h0006;
    step();
    check("midrst_regrant", {16'h0, gnt}, 32'h0002);
    req = 16'h0000;
    step();
    step();
    step();

    check("sb_leftover", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
